multi_cycle_adder: RTL

MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

---
 rtl/multi_cycle_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: ripple adder/subtractor that processes CHUNK bits per
// clock, from the least significant chunk upward. It runs one operation at a
// time under a valid/ready handshake on both the input and the output side.
// The result is held in DONE until the consumer takes it.
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtraction
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;

  logic [CHUNK-1:0] a_chunk_d;
  logic [CHUNK-1:0] b_chunk_d;
  logic [CHUNK-1:0] s_chunk_d;
  logic             carry_d;
  logic             msb_cin_d;
  logic             accept;

  // One chunk of the ripple add: {carry out, CHUNK-bit sum}.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  assign accept = in_valid & in_ready_q;

  // Select chunk k of both operands and add it with the running carry.
  always_comb begin
    a_chunk_d = '0;
    b_chunk_d = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk_d = a_q[i*CHUNK +: CHUNK];
        b_chunk_d = b_q[i*CHUNK +: CHUNK];
      end
    end
    {carry_d, s_chunk_d} = chunk_add(a_chunk_d, b_chunk_d, carry_q);
    // Carry into the top bit of this chunk; it is the MSB carry-in on the last chunk.
    msb_cin_d = a_chunk_d[CHUNK-1] ^ b_chunk_d[CHUNK-1] ^ s_chunk_d[CHUNK-1];
  end

  // Capture the operands on acceptance. These registers need no reset because
  // the FSM only reads them after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  // Control FSM, with the result and the handshake flags as registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      carry_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the initial carry is sub.
            k_q        <= '0;
            carry_q    <= sub;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) sum_q[i*CHUNK +: CHUNK] <= s_chunk_d;
          end
          carry_q <= carry_d;
          k_q     <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            cout_q      <= carry_d;
            ovf_q       <= msb_cin_d ^ carry_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
